// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS main controller and its datapath.
//   Inputs to the controller : opcode[5:0], zero, mem_ready
//   Outputs of the controller: memory strobes (mem_read, mem_write, iord),
//     register enables (ir_write, pc_en, reg_write), mux selects
//     (pc_source, alu_src_a, alu_src_b, reg_dst, mem_to_reg), alu_op,
//     status (illegal_op, instr_done) and the debug state[3:0].
// master = controller side, slave = datapath side.
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       pc_en;
  logic [1:0] pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal_op;
  logic       instr_done;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_en, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
           illegal_op, instr_done, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_en, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
           illegal_op, instr_done, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch / decode / execute / memory / write-back and drives all
// datapath selects, enables and memory strobes. Memory steps wait on
// mem_ready, so variable-latency memory is tolerated.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset; all outputs read 0 while low
//   bus    - controller side of mips_multicycle_control_if (see that file)
module mips_multicycle_control (
  input  logic                             clk,
  input  logic                             rst_n,
  mips_multicycle_control_if.master        bus
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] JUMP   = 4'd9;
  localparam logic [3:0] ADDIEX = 4'd10;
  localparam logic [3:0] ADDIWB = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [5:0] op_q;
  logic       op_legal;

  always_comb begin
    op_legal = 1'b0;
    case (bus.opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: state_d = (op_q == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (bus.mem_ready) state_d = MEMWB;
      MEMWR:  if (bus.mem_ready) state_d = FETCH;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= bus.opcode;
    end
  end

  // Outputs are gated by rst_n so a reset mid-instruction kills every
  // strobe immediately, not just at the next edge.
  always_comb begin
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_en      = 1'b0;
    bus.pc_source  = 2'b00;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.illegal_op = 1'b0;
    bus.instr_done = 1'b0;
    bus.state      = state_q;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          bus.pc_en     = bus.mem_ready;
        end
        DECODE: begin
          bus.alu_src_b  = 2'b11;
          bus.illegal_op = ~op_legal;
          bus.instr_done = ~op_legal;
        end
        MEMADR, ADDIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        MEMRD: begin
          bus.mem_read = 1'b1;
          bus.iord     = 1'b1;
        end
        MEMWR: begin
          bus.mem_write  = 1'b1;
          bus.iord       = 1'b1;
          bus.instr_done = bus.mem_ready;
        end
        MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          bus.instr_done = 1'b1;
        end
        EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b10;
        end
        ALUWB: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 1'b1;
          bus.instr_done = 1'b1;
        end
        ADDIWB: begin
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
        end
        BRANCH: begin
          bus.alu_src_a  = 1'b1;
          bus.alu_op     = 2'b01;
          bus.pc_source  = 2'b01;
          bus.pc_en      = bus.zero;
          bus.instr_done = 1'b1;
        end
        JUMP: begin
          bus.pc_source  = 2'b10;
          bus.pc_en      = 1'b1;
          bus.instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;

  logic clk;
  logic rst_n;

  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic        zero;
    logic        rdy;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [5:0] L = 6'b100011;
  localparam logic [5:0] S = 6'b101011;
  localparam logic [5:0] B = 6'b000100;
  localparam logic [5:0] J = 6'b000010;
  localparam logic [5:0] R = 6'b000000;
  localparam logic [5:0] A = 6'b001000;
  localparam logic [5:0] X = 6'b111111;

  // Expected output word: field order matches actual() below.
  function automatic logic [20:0] e(
    input logic [3:0] st,
    input logic mr, input logic mw, input logic io, input logic irw, input logic pce,
    input logic [1:0] pcs, input logic asa, input logic [1:0] asb, input logic [1:0] aop,
    input logic rw, input logic rd, input logic m2r, input logic ill, input logic dn);
    return {mr, mw, io, irw, pce, pcs, asa, asb, aop, rw, rd, m2r, ill, dn, st};
  endfunction

  function automatic logic [20:0] actual();
    return {bus.mem_read, bus.mem_write, bus.iord, bus.ir_write, bus.pc_en,
            bus.pc_source, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.illegal_op,
            bus.instr_done, bus.state};
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic z, input logic r, input logic [20:0] x);
    vec_t v;
    v.op = op; v.zero = z; v.rdy = r; v.exp = x;
    vecs.push_back(v);
  endtask

  logic [20:0] f1, f0, dec, madr, mrd, mwb, mwr0, mwr1, br1, br0;
  logic [20:0] exe, aluwb, addiex, addiwb, jmp, dill, zeros;

  initial begin
    f1     = e(4'd0, 1,0,0,1,1, 2'b00, 0, 2'b01, 2'b00, 0,0,0,0,0);
    f0     = e(4'd0, 1,0,0,0,0, 2'b00, 0, 2'b01, 2'b00, 0,0,0,0,0);
    dec    = e(4'd1, 0,0,0,0,0, 2'b00, 0, 2'b11, 2'b00, 0,0,0,0,0);
    madr   = e(4'd2, 0,0,0,0,0, 2'b00, 1, 2'b10, 2'b00, 0,0,0,0,0);
    mrd    = e(4'd3, 1,0,1,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0,0,0);
    mwb    = e(4'd4, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 1,0,1,0,1);
    mwr0   = e(4'd5, 0,1,1,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0,0,0);
    mwr1   = e(4'd5, 0,1,1,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0,0,1);
    br1    = e(4'd8, 0,0,0,0,1, 2'b01, 1, 2'b00, 2'b01, 0,0,0,0,1);
    br0    = e(4'd8, 0,0,0,0,0, 2'b01, 1, 2'b00, 2'b01, 0,0,0,0,1);
    exe    = e(4'd6, 0,0,0,0,0, 2'b00, 1, 2'b00, 2'b10, 0,0,0,0,0);
    aluwb  = e(4'd7, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 1,1,0,0,1);
    addiex = e(4'd10,0,0,0,0,0, 2'b00, 1, 2'b10, 2'b00, 0,0,0,0,0);
    addiwb = e(4'd11,0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 1,0,0,0,1);
    jmp    = e(4'd9, 0,0,0,0,1, 2'b10, 0, 2'b00, 2'b00, 0,0,0,0,1);
    dill   = e(4'd1, 0,0,0,0,0, 2'b00, 0, 2'b11, 2'b00, 0,0,0,1,1);
    zeros  = '0;

    // lw, no waits: 0,1,2,3,4
    add(L,0,1,f1); add(L,0,1,dec); add(L,0,1,madr); add(L,0,1,mrd); add(L,0,1,mwb);
    // sw, MEMWR waits 3 cycles
    add(S,0,1,f1); add(S,0,1,dec); add(S,0,1,madr);
    add(S,0,0,mwr0); add(S,0,0,mwr0); add(S,0,0,mwr0); add(S,0,1,mwr1);
    // beq taken, then not taken
    add(B,0,1,f1); add(B,0,1,dec); add(B,1,1,br1);
    add(B,0,1,f1); add(B,0,1,dec); add(B,0,1,br0);
    // R-type (zero ignored outside BRANCH), then addi
    add(R,0,1,f1); add(R,0,1,dec); add(R,1,1,exe); add(R,0,1,aluwb);
    add(A,0,1,f1); add(A,0,1,dec); add(A,0,1,addiex); add(A,0,1,addiwb);
    // jump
    add(J,0,1,f1); add(J,0,1,dec); add(J,0,1,jmp);
    // illegal opcode: 2 cycles
    add(X,0,1,f1); add(X,0,1,dill);
    // lw with FETCH and MEMRD waits; opcode changes after DECODE must not matter
    add(L,0,0,f0); add(L,0,1,f1); add(L,0,0,dec); add(S,0,0,madr);
    add(S,0,0,mrd); add(S,0,1,mrd); add(S,0,1,mwb);

    rst_n = 1'b0;
    bus.opcode = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    #2 check("reset_outputs", actual(), zeros);
    #5 rst_n = 1'b1;  // release mid-cycle, between posedge 5 and negedge 10

    for (int i = 0; i < vecs.size(); i++) begin
      bus.opcode    = vecs[i].op;
      bus.zero      = vecs[i].zero;
      bus.mem_ready = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d", i), actual(), vecs[i].exp);
      @(posedge clk);
      #1;
    end

    // Now in FETCH: run lw into MEMRD, then reset mid-clock.
    bus.opcode = L; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    check("seq_fetch", actual(), f1);
    repeat (3) @(posedge clk);
    #2 check("seq_memrd", actual(), mrd);
    #1 rst_n = 1'b0;
    #1 check("rst_immediate", actual(), zeros);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1 check($sformatf("rst_hold%0d", k), actual(), zeros);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 check("rst_release_fetch", actual(), f1);
    @(posedge clk);
    #1 check("rst_release_decode", actual(), dec);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control finite-state machine for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back steps. It drives every datapath mux, register-enable and memory strobe, and supplies the 2-bit `alu_op` consumed by the ALU control decoder. Memory accesses use a ready handshake, so variable-latency memory is tolerated.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  instr[31:26] from the instruction register
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current read/write this cycle
- `mem_read`  out  1  memory read strobe
- `mem_write`  out  1  memory write strobe
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `ir_write`  out  1  instruction register load enable
- `pc_en`  out  1  PC load enable (branch condition already resolved internally)
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `alu_src_a`  out  1  0 = PC, 1 = register A
- `alu_src_b`  out  2  00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- `alu_op`  out  2  00 = add, 01 = subtract, 10 = use funct field
- `reg_write`  out  1  register file write enable
- `reg_dst`  out  1  0 = rt, 1 = rd
- `mem_to_reg`  out  1  0 = ALUOut, 1 = MDR
- `illegal_op`  out  1  unsupported opcode detected
- `instr_done`  out  1  final cycle of an instruction
- `state`  out  4  current state (debug/verification)

## Operation
- States and encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, ALUWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Opcode is registered into `op_q` on the DECODE→next edge. All later branching uses `op_q`.
- Transitions:
  - FETCH→DECODE when `mem_ready`; otherwise stay in FETCH.
  - DECODE→MEMADR for lw/sw, EXEC for R-type, BRANCH for beq, JUMP for j, ADDIEX for addi.
  - DECODE→FETCH for any other opcode.
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB when `mem_ready`; MEMWR→FETCH when `mem_ready`; otherwise stay.
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP→FETCH.
  - EXEC→ALUWB; ADDIEX→ADDIWB.
- Per-state outputs (any output not listed is 0):
  - FETCH: `mem_read`=1, `alu_src_b`=01, `ir_write`=`pc_en`=`mem_ready`.
  - DECODE: `alu_src_b`=11; `illegal_op`=1 if the opcode is unsupported.
  - MEMADR and ADDIEX: `alu_src_a`=1, `alu_src_b`=10.
  - MEMRD: `mem_read`=1, `iord`=1.
  - MEMWR: `mem_write`=1, `iord`=1, `instr_done`=`mem_ready`.
  - MEMWB: `reg_write`=1, `mem_to_reg`=1, `instr_done`=1.
  - EXEC: `alu_src_a`=1, `alu_op`=10.
  - ALUWB: `reg_write`=1, `reg_dst`=1, `instr_done`=1.
  - ADDIWB: `reg_write`=1, `instr_done`=1.
  - BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_source`=01, `pc_en`=`zero`, `instr_done`=1.
  - JUMP: `pc_source`=10, `pc_en`=1, `instr_done`=1.
  - DECODE with an illegal opcode also asserts `instr_done`=1.
- Strobes are held steady for the whole memory wait; no other output changes while waiting.

## Timing
- Reset:
  - `rst_n` low asynchronously forces state to FETCH and clears `op_q`.
  - While `rst_n`=0, every output is forced to 0 combinationally, except `state`, which reads 0.
  - The first FETCH strobe appears in the same cycle `rst_n` deasserts.
- Reset mid-instruction aborts immediately. No `reg_write`, `mem_write` or `pc_en` is issued after `rst_n` falls.
- Outputs are decoded combinationally from state. The only input-dependent terms are `mem_ready`, `zero` and `opcode` (DECODE only).
- Cycle counts with `mem_ready` tied to 1:
  - 5 cycles: lw
  - 4 cycles: sw, R-type, addi
  - 3 cycles: beq, j
  - 2 cycles: illegal opcode
- Each wait cycle in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
- `mem_ready` is ignored in every state other than FETCH, MEMRD and MEMWR.
- `zero` is sampled only in BRANCH.

## Test plan
- lw with `mem_ready`=1: `state` sequence 0,1,2,3,4,0. In MEMWB, `reg_write`=1 and `mem_to_reg`=1. `instr_done` pulses once, in cycle 5.
- sw with `mem_ready` low for 3 cycles in MEMWR: `state` holds 5 for 4 cycles with `mem_write`=1 and `iord`=1 steady. `instr_done` asserts only in the cycle where `mem_ready`=1.
- beq with `zero`=1, then again with `zero`=0: `state` sequence 0,1,8,0 in both cases. In BRANCH, `pc_source`=01 and `alu_op`=01; `pc_en` is 1, then 0.
- R-type followed by addi: `alu_op`=10 and `reg_dst`=1 in R-type EXEC/ALUWB. For addi, `alu_src_b`=10 in ADDIEX and `reg_dst`=0 in ADDIWB.
- Opcode 111111: `illegal_op`=1 and `instr_done`=1 in DECODE, next `state`=0, and no `reg_write`, `mem_write` or `pc_en` outside FETCH.
- Pull `rst_n` low mid-clock during MEMRD: all outputs become 0 at once and `state` reads 0. After release, FETCH restarts with `mem_read`=1 and `alu_src_b`=01.
